// File: rtl/rxr_to_noc_packetizer_if.sv
// Bundle of the ingress Avalon-ST beat signals and the NoC egress flit
// handshake used by rxr_to_noc_packetizer.
//   master : upstream/downstream environment (drives beats, drives o_ready_in)
//   slave  : the packetizer (accepts beats, drives flits)
// Signals keep the packetizer's original port names.
interface rxr_to_noc_packetizer_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NOC_WIDTH  = 600,
  parameter int unsigned DST_W      = 4,
  parameter int unsigned VC_W       = 1
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sop;
  logic                  in_eop;
  logic [5:0]            in_empty;
  logic [DST_W-1:0]      i_dst_in;
  logic [VC_W-1:0]       i_vc_in;
  logic [NOC_WIDTH-1:0]  o_data_out;
  logic                  o_valid_out;
  logic                  o_ready_in;

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, i_dst_in, i_vc_in,
    output o_ready_in,
    input  in_ready, o_data_out, o_valid_out
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, i_dst_in, i_vc_in,
    input  o_ready_in,
    output in_ready, o_data_out, o_valid_out
  );
endinterface

// File: rtl/rxr_to_noc_packetizer.sv
// Packs Ethernet receiver Avalon-ST beats into NoC flits, one flit per beat.
// Enforces sop/eop framing (malformed beats are dropped and counted) and
// drives the NoC router through a registered output stage with a one-entry
// skid buffer.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : ingress beats (in_*, i_dst_in, i_vc_in, in_ready) and
//                    egress flits (o_data_out, o_valid_out, o_ready_in)
//   o_pkt_count    : packets forwarded, counted on the accepted tail flit
//   o_drop_count   : malformed beats dropped, saturating
// Flit layout from LSB: data | empty(6) | sop | eop | vc | dst | head | tail | 0...
module rxr_to_noc_packetizer #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NOC_WIDTH  = 600,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned NOC_RADIX  = 16,
  parameter int unsigned VC_ROTATE  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  rxr_to_noc_packetizer_if.slave  bus,
  output logic [31:0]             o_pkt_count,
  output logic [15:0]             o_drop_count
);

  localparam int unsigned VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned DST_W     = (NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1;
  localparam int unsigned EMPTY_LSB = DATA_WIDTH;
  localparam int unsigned SOP_BIT   = DATA_WIDTH + 6;
  localparam int unsigned EOP_BIT   = DATA_WIDTH + 7;
  localparam int unsigned VC_LSB    = DATA_WIDTH + 8;
  localparam int unsigned DST_LSB   = VC_LSB + VC_W;
  localparam int unsigned HEAD_BIT  = DST_LSB + DST_W;
  localparam int unsigned TAIL_BIT  = HEAD_BIT + 1;

  if (NOC_WIDTH < TAIL_BIT + 1) begin : g_width_check
    $error("NOC_WIDTH too small for data plus flit header");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_PKT,
    S_DROP
  } state_e;

  state_e                state_q, state_d;
  logic                  in_ready_q;
  logic                  beat_acc;
  logic                  fwd;
  logic                  drop_inc;
  logic                  latch_hdr;
  logic                  f_sop, f_eop;
  logic [5:0]            f_empty;
  logic [DST_W-1:0]      f_dst, dst_q;
  logic [VC_W-1:0]       f_vc, vc_q, vc_sel, vc_ptr_q;
  logic [NOC_WIDTH-1:0]  flit;
  logic [NOC_WIDTH-1:0]  out_q, skid_q;
  logic                  out_valid_q, skid_full_q, skid_full_d;
  logic                  out_ld;
  logic [31:0]           pkt_q;
  logic [15:0]           drop_q;

  assign bus.in_ready    = in_ready_q;
  assign bus.o_data_out  = out_q;
  assign bus.o_valid_out = out_valid_q;
  assign o_pkt_count     = pkt_q;
  assign o_drop_count    = drop_q;

  assign beat_acc = bus.in_valid && in_ready_q;
  assign vc_sel   = (VC_ROTATE != 0) ? vc_ptr_q : bus.i_vc_in;

  // Framing FSM: decides per accepted beat whether it is forwarded, and how
  // its sop/eop/empty fields are rewritten.
  always_comb begin
    state_d   = state_q;
    fwd       = 1'b0;
    drop_inc  = 1'b0;
    latch_hdr = 1'b0;
    f_sop     = bus.in_sop;
    f_eop     = bus.in_eop;
    f_empty   = bus.in_empty;
    if (beat_acc) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_sop) begin
            fwd       = 1'b1;
            latch_hdr = 1'b1;
            state_d   = bus.in_eop ? S_IDLE : S_IN_PKT;
          end else begin
            drop_inc = 1'b1;
            state_d  = bus.in_eop ? S_IDLE : S_DROP;
          end
        end
        S_IN_PKT: begin
          fwd = 1'b1;
          if (bus.in_sop) begin
            // Unexpected sop closes the running packet: this beat becomes its
            // tail, and the packet it tried to open is discarded.
            f_sop    = 1'b0;
            f_eop    = 1'b1;
            f_empty  = '0;
            drop_inc = 1'b1;
            state_d  = bus.in_eop ? S_IDLE : S_DROP;
          end else if (bus.in_eop) begin
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          drop_inc = 1'b1;
          if (bus.in_eop) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The sop beat uses live dst/vc since the latches update on the same edge.
  assign f_dst = latch_hdr ? bus.i_dst_in : dst_q;
  assign f_vc  = latch_hdr ? vc_sel : vc_q;

  always_comb begin
    flit                           = '0;
    flit[DATA_WIDTH-1:0]           = bus.in_data;
    flit[SOP_BIT-1:EMPTY_LSB]      = f_empty;
    flit[SOP_BIT]                  = f_sop;
    flit[EOP_BIT]                  = f_eop;
    flit[DST_LSB-1:VC_LSB]         = f_vc;
    flit[HEAD_BIT-1:DST_LSB]       = f_dst;
    flit[HEAD_BIT]                 = f_sop;
    flit[TAIL_BIT]                 = f_eop;
  end

  // Output register can take a new flit when empty or being consumed. The skid
  // always drains first; in_ready is low while it is full, so no beat can
  // arrive in the draining cycle.
  assign out_ld      = !out_valid_q || bus.o_ready_in;
  assign skid_full_d = out_ld ? 1'b0 : (skid_full_q || fwd);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      dst_q       <= '0;
      vc_q        <= '0;
      vc_ptr_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= !skid_full_d;
      skid_full_q <= skid_full_d;

      if (latch_hdr) begin
        dst_q <= bus.i_dst_in;
        vc_q  <= vc_sel;
      end

      // The pointer advances when the tail enters the pipeline; the output
      // path never drops flits, so this matches tail-acceptance order while
      // letting a back-to-back next packet see the advanced value.
      if (fwd && f_eop) begin
        if (vc_ptr_q == VC_W'(NUM_VC - 1)) vc_ptr_q <= '0;
        else                               vc_ptr_q <= vc_ptr_q + VC_W'(1);
      end

      if (out_ld) begin
        if (skid_full_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= fwd;
          if (fwd) out_q <= flit;
        end
      end else if (fwd) begin
        skid_q <= flit;
      end

      if (out_valid_q && bus.o_ready_in && out_q[TAIL_BIT]) pkt_q <= pkt_q + 32'd1;
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_rxr_to_noc_packetizer.sv
// Directed bench for rxr_to_noc_packetizer: a table of beats with expected
// flits/counters, plus hand-written stall and mid-packet-reset sequences.
module tb_rxr_to_noc_packetizer;

  localparam int unsigned DW     = 512;
  localparam int unsigned NW     = 600;
  localparam int unsigned E_L    = 512;
  localparam int unsigned SOP_B  = 518;
  localparam int unsigned EOP_B  = 519;
  localparam int unsigned VC_B   = 520;
  localparam int unsigned DST_L  = 521;
  localparam int unsigned HEAD_B = 525;
  localparam int unsigned TAIL_B = 526;

  typedef struct {
    logic        rst;
    logic        vld;
    logic        sop;
    logic        eop;
    logic [5:0]  emp;
    logic [3:0]  dst;
    logic [31:0] tag;
    logic        ov;
    logic        fsop;
    logic        feop;
    logic        fhead;
    logic        ftail;
    logic [5:0]  fempty;
    logic [3:0]  fdst;
    logic        fvc;
    logic [31:0] pkt;
    logic [15:0] drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pkt;
  logic [15:0] drop;

  int passed = 0;
  int total  = 0;

  rxr_to_noc_packetizer_if #(.DATA_WIDTH(DW), .NOC_WIDTH(NW), .DST_W(4), .VC_W(1)) bus ();

  rxr_to_noc_packetizer #(
    .DATA_WIDTH(DW),
    .NOC_WIDTH (NW),
    .NUM_VC    (2),
    .NOC_RADIX (16),
    .VC_ROTATE (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_pkt_count (pkt),
    .o_drop_count(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", bus.o_valid_out, 1'b0);
    chk("rst_data_zero", bus.o_data_out == '0, 1'b1);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_pkt", pkt, 0);
    chk("rst_drop", drop, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
  endtask

  vec_t        vecs[20];
  logic [31:0] got_tag[$];
  logic [NW-1:0] got_flit[$];
  int          acc_cnt;
  int          first_low;
  int          tries;
  logic        acc;
  logic        stalled;
  logic [NW-1:0] held;
  logic [DW-1:0] expd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst vld sop eop emp dst tag     ov fsop feop fhead ftail femp fdst fvc pkt drop
    vecs[0]  = '{0, 1, 1, 0, 0, 5, 'h10,  1, 1, 0, 1, 0, 0, 5, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 9, 'h11,  1, 0, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 7, 9, 'h12,  1, 0, 1, 0, 1, 7, 5, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 'h0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{1, 1, 1, 1, 3, 2, 'h20,  1, 1, 1, 1, 1, 3, 2, 0, 0, 0};
    vecs[5]  = '{0, 1, 1, 1, 0, 3, 'h21,  1, 1, 1, 1, 1, 0, 3, 1, 1, 0};
    vecs[6]  = '{0, 1, 1, 1, 1, 4, 'h22,  1, 1, 1, 1, 1, 1, 4, 0, 2, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 'h0,   0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 0, 'h30,  0, 0, 0, 0, 0, 0, 0, 0, 3, 1};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 'h31,  0, 0, 0, 0, 0, 0, 0, 0, 3, 2};
    vecs[10] = '{0, 1, 0, 1, 0, 0, 'h32,  0, 0, 0, 0, 0, 0, 0, 0, 3, 3};
    vecs[11] = '{0, 1, 1, 1, 2, 6, 'h33,  1, 1, 1, 1, 1, 2, 6, 1, 3, 3};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 'h0,   0, 0, 0, 0, 0, 0, 0, 0, 4, 3};
    vecs[13] = '{0, 1, 1, 0, 0, 7, 'h40,  1, 1, 0, 1, 0, 0, 7, 0, 4, 3};
    vecs[14] = '{0, 1, 0, 0, 0, 2, 'h41,  1, 0, 0, 0, 0, 0, 7, 0, 4, 3};
    vecs[15] = '{0, 1, 1, 0, 5, 8, 'h42,  1, 0, 1, 0, 1, 0, 7, 0, 4, 4};
    vecs[16] = '{0, 1, 0, 0, 0, 0, 'h43,  0, 0, 0, 0, 0, 0, 0, 0, 5, 5};
    vecs[17] = '{0, 1, 0, 1, 1, 0, 'h44,  0, 0, 0, 0, 0, 0, 0, 0, 5, 6};
    vecs[18] = '{0, 1, 1, 1, 0, 1, 'h45,  1, 1, 1, 1, 1, 0, 1, 1, 5, 6};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 'h0,   0, 0, 0, 0, 0, 0, 0, 0, 6, 6};

    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_empty   = '0;
    bus.i_dst_in   = '0;
    bus.i_vc_in    = 1'b1;
    bus.o_ready_in = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Table: one beat per cycle, NoC always ready, flit checked 1 cycle later.
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rst) do_reset();
      chk($sformatf("in_ready_v%0d", i), bus.in_ready, 1'b1);
      bus.in_valid = vecs[i].vld;
      bus.in_sop   = vecs[i].sop;
      bus.in_eop   = vecs[i].eop;
      bus.in_empty = vecs[i].emp;
      bus.i_dst_in = vecs[i].dst;
      bus.in_data  = {16{vecs[i].tag}};
      @(posedge clk); #1;
      chk($sformatf("valid_v%0d", i), bus.o_valid_out, vecs[i].ov);
      if (vecs[i].ov) begin
        expd = {16{vecs[i].tag}};
        chk($sformatf("data_v%0d", i), bus.o_data_out[DW-1:0] == expd, 1'b1);
        chk($sformatf("empty_v%0d", i), bus.o_data_out[SOP_B-1:E_L], vecs[i].fempty);
        chk($sformatf("sop_v%0d", i), bus.o_data_out[SOP_B], vecs[i].fsop);
        chk($sformatf("eop_v%0d", i), bus.o_data_out[EOP_B], vecs[i].feop);
        chk($sformatf("vc_v%0d", i), bus.o_data_out[VC_B], vecs[i].fvc);
        chk($sformatf("dst_v%0d", i), bus.o_data_out[HEAD_B-1:DST_L], vecs[i].fdst);
        chk($sformatf("head_v%0d", i), bus.o_data_out[HEAD_B], vecs[i].fhead);
        chk($sformatf("tail_v%0d", i), bus.o_data_out[TAIL_B], vecs[i].ftail);
        chk($sformatf("msb_zero_v%0d", i), bus.o_data_out[NW-1:TAIL_B+1] == '0, 1'b1);
      end
      chk($sformatf("pkt_v%0d", i), pkt, vecs[i].pkt);
      chk($sformatf("drop_v%0d", i), drop, vecs[i].drop);
    end
    bus.in_valid = 1'b0;

    // Stall: 5-beat packet while the NoC holds off for 4 cycles.
    acc_cnt   = 0;
    first_low = -1;
    stalled   = 1'b0;
    held      = '0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          bus.in_valid = 1'b1;
          bus.in_sop   = (k == 0);
          bus.in_eop   = (k == 4);
          bus.in_empty = (k == 4) ? 6'd9 : 6'd0;
          bus.i_dst_in = 4'd11;
          bus.in_data  = {16{32'h50 + k}};
          tries = 0;
          do begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            tries++;
          end while (!acc && tries < 20);
          if (!acc) chk("stall_accept_timeout", 0, 1);
          acc_cnt++;
        end
        bus.in_valid = 1'b0;
      end
      begin
        bus.o_ready_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.o_ready_in = 1'b1;
      end
      begin
        repeat (25) begin
          @(negedge clk);
          if (stalled) chk("stall_hold", bus.o_valid_out && (bus.o_data_out == held), 1'b1);
          if (!bus.in_ready && first_low < 0) first_low = acc_cnt;
          if (bus.o_valid_out && bus.o_ready_in) begin
            got_tag.push_back(bus.o_data_out[31:0]);
            got_flit.push_back(bus.o_data_out);
          end
          stalled = bus.o_valid_out && !bus.o_ready_in;
          held    = bus.o_data_out;
        end
      end
    join
    chk("stall_in_ready_fall_after", first_low, 2);
    chk("stall_flit_count", got_tag.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_tag.size()) begin
        chk($sformatf("stall_order_%0d", k), got_tag[k], 32'h50 + k);
        chk($sformatf("stall_head_%0d", k), got_flit[k][HEAD_B], k == 0);
        chk($sformatf("stall_tail_%0d", k), got_flit[k][TAIL_B], k == 4);
        chk($sformatf("stall_dst_%0d", k), got_flit[k][HEAD_B-1:DST_L], 4'd11);
        chk($sformatf("stall_vc_%0d", k), got_flit[k][VC_B], 1'b0);
      end
    end
    if (got_flit.size() == 5) chk("stall_last_empty", got_flit[4][SOP_B-1:E_L], 6'd9);
    chk("stall_pkt", pkt, 7);
    chk("stall_drop", drop, 6);

    // Reset in the middle of a packet, then a fresh single-beat packet.
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b1;
    bus.in_eop   = 1'b0;
    bus.in_empty = '0;
    bus.i_dst_in = 4'd3;
    bus.in_data  = {16{32'h60}};
    @(posedge clk); #1;
    bus.in_sop  = 1'b0;
    bus.in_data = {16{32'h61}};
    @(posedge clk); #1;
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b1;
    bus.in_eop   = 1'b1;
    bus.i_dst_in = 4'd12;
    bus.in_data  = {16{32'h70}};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_rst_valid", bus.o_valid_out, 1'b1);
    chk("mid_rst_tag", bus.o_data_out[31:0], 32'h70);
    chk("mid_rst_head", bus.o_data_out[HEAD_B], 1'b1);
    chk("mid_rst_vc", bus.o_data_out[VC_B], 1'b0);
    chk("mid_rst_dst", bus.o_data_out[HEAD_B-1:DST_L], 4'd12);
    @(posedge clk); #1;
    chk("mid_rst_pkt", pkt, 1);
    chk("mid_rst_drop", drop, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
